// File: rtl/serv_csr_pkg.sv
// rtl/serv_csr_pkg.sv - shared constants and helpers for the serial CSR/interrupt unit
package serv_csr_pkg;

   localparam logic [1:0] CSR_SOURCE_CSR = 2'b00;
   localparam logic [1:0] CSR_SOURCE_EXT = 2'b01;
   localparam logic [1:0] CSR_SOURCE_SET = 2'b10;
   localparam logic [1:0] CSR_SOURCE_CLR = 2'b11;

   // mie/mip bit positions; local line k lives at LIRQ_BIT+k
   localparam int MSI_BIT  = 3;
   localparam int MTI_BIT  = 7;
   localparam int MEI_BIT  = 11;
   localparam int LIRQ_BIT = 16;

   localparam logic [4:0] CAUSE_MISALIGNED_JUMP  = 5'd0;
   localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
   localparam logic [4:0] CAUSE_MISALIGNED_LOAD  = 5'd4;
   localparam logic [4:0] CAUSE_MISALIGNED_STORE = 5'd6;
   localparam logic [4:0] CAUSE_ECALL            = 5'd11;
   localparam logic [4:0] CAUSE_MSI              = 5'd3;
   localparam logic [4:0] CAUSE_MTI              = 5'd7;
   localparam logic [4:0] CAUSE_MEI              = 5'd11;

   // Cause code for a synchronous trap, from the decoder's qualifiers
   function automatic logic [4:0] exception_code(input logic e_op, input logic ebreak,
                                                 input logic mem_op, input logic mem_cmd);
      if (e_op)
         return ebreak ? CAUSE_BREAKPOINT : CAUSE_ECALL;
      else if (mem_op)
         return mem_cmd ? CAUSE_MISALIGNED_STORE : CAUSE_MISALIGNED_LOAD;
      else
         return CAUSE_MISALIGNED_JUMP;
   endfunction

   // Mask of implemented mie/mip bits
   function automatic logic [31:0] irq_mask(input int num_irq);
      logic [31:0] m;
      m = '0;
      m[MSI_BIT] = 1'b1;
      m[MTI_BIT] = 1'b1;
      m[MEI_BIT] = 1'b1;
      for (int k = 0; k < num_irq; k++)
         m[LIRQ_BIT+k] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/serv_irq_prio.sv
// rtl/serv_irq_prio.sv - interrupt line synchronisers, mip register and priority encoder
module serv_irq_prio
   import serv_csr_pkg::*;
#(
   parameter int NUM_IRQ     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_lines,
   input  logic [31:0] i_mie,
   output logic [31:0] o_mip,
   output logic        o_any,
   output logic [4:0]  o_code
);

   localparam logic [31:0] IMPL = irq_mask(NUM_IRQ);

   logic [31:0] synced;
   logic [31:0] mip_q;
   logic [31:0] p;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign synced = i_lines;
      end else begin : g_sync
         logic [31:0] sync_q [SYNC_STAGES];
         // Shift the raw lines through the synchroniser chain
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int k = 0; k < SYNC_STAGES; k++)
                  sync_q[k] <= '0;
            end else begin
               sync_q[0] <= i_lines;
               for (int k = 1; k < SYNC_STAGES; k++)
                  sync_q[k] <= sync_q[k-1];
            end
         end
         assign synced = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // mip holds the synchronised level of every implemented line
   always_ff @(posedge i_clk) begin
      if (i_rst)
         mip_q <= '0;
      else
         mip_q <= synced & IMPL;
   end

   assign o_mip = mip_q;
   assign p     = mip_q & i_mie;

   // Fixed priority: external, software, timer, then local lines lowest index first
   always_comb begin
      o_any  = |p;
      o_code = '0;
      if (p[MEI_BIT])
         o_code = CAUSE_MEI;
      else if (p[MSI_BIT])
         o_code = CAUSE_MSI;
      else if (p[MTI_BIT])
         o_code = CAUSE_MTI;
      else begin
         for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (p[LIRQ_BIT+k])
               o_code = 5'(LIRQ_BIT + k);
      end
   end

endmodule

// File: rtl/serv_csr_irq.sv
// rtl/serv_csr_irq.sv - bit-serial machine-mode CSR and interrupt unit
module serv_csr_irq
   import serv_csr_pkg::*;
#(
   parameter int NUM_IRQ     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_init,
   input  logic               i_en,
   input  logic               i_cnt_done,
   input  logic [4:0]         i_cnt,
   input  logic               i_trap,
   input  logic               i_mret,
   input  logic               i_e_op,
   input  logic               i_ebreak,
   input  logic               i_mem_op,
   input  logic               i_mem_cmd,
   input  logic               i_mstatus_en,
   input  logic               i_mie_en,
   input  logic               i_mip_en,
   input  logic               i_mcause_en,
   input  logic [1:0]         i_csr_source,
   input  logic               i_csr_d_sel,
   input  logic               i_csr_imm,
   input  logic               i_rs1,
   input  logic               i_rf_csr_out,
   input  logic               i_mtip,
   input  logic               i_msip,
   input  logic               i_meip,
   input  logic [NUM_IRQ-1:0] i_lirq,
   output logic               o_csr_in,
   output logic               o_q,
   output logic               o_new_irq,
   output logic               o_irq_pending
);

   localparam logic [31:0] IMPL = irq_mask(NUM_IRQ);

   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic [31:0] mie_q;
   logic [4:0]  mcause_code;
   logic        mcause_int;
   logic [4:0]  irq_code;
   logic [31:0] lines;
   logic [31:0] mip;
   logic        irq_any;
   logic [4:0]  prio_code;
   logic        d;
   logic        csr_out;
   logic        mstatus_bit;
   logic        mcause_bit;

   // Gather the interrupt inputs into their mip bit positions
   always_comb begin
      lines                      = '0;
      lines[MSI_BIT]             = i_msip;
      lines[MTI_BIT]             = i_mtip;
      lines[MEI_BIT]             = i_meip;
      lines[LIRQ_BIT +: NUM_IRQ] = i_lirq;
   end

   serv_irq_prio #(
      .NUM_IRQ     (NUM_IRQ),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_prio (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_lines (lines),
      .i_mie   (mie_q),
      .o_mip   (mip),
      .o_any   (irq_any),
      .o_code  (prio_code)
   );

   // Serial read mux and write/set/clear operation on the current bit
   always_comb begin
      d           = i_csr_d_sel ? i_csr_imm : i_rs1;
      mstatus_bit = ((i_cnt == 5'd3) & mstatus_mie) | ((i_cnt == 5'd7) & mstatus_mpie);
      mcause_bit  = ((i_cnt < 5'd5) & mcause_code[0]) | (i_cnt_done & mcause_int);
      csr_out     = i_rf_csr_out
                  | (i_mstatus_en & mstatus_bit)
                  | (i_mie_en & mie_q[i_cnt])
                  | (i_mip_en & mip[i_cnt])
                  | (i_mcause_en & mcause_bit);
      o_q         = csr_out;
      o_csr_in    = csr_out;
      case (i_csr_source)
         CSR_SOURCE_CSR: o_csr_in = csr_out;
         CSR_SOURCE_EXT: o_csr_in = d;
         CSR_SOURCE_SET: o_csr_in = csr_out | d;
         CSR_SOURCE_CLR: o_csr_in = csr_out & ~d;
         default:        o_csr_in = csr_out;
      endcase
   end

   // CSR writes, interrupt acceptance, then trap/mret which override both
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mcause_code  <= '0;
         mcause_int   <= 1'b0;
         irq_code     <= '0;
         o_new_irq    <= 1'b0;
      end else begin
         if (i_mstatus_en & i_en & (i_cnt == 5'd3))
            mstatus_mie <= o_csr_in;
         if (i_mstatus_en & i_en & (i_cnt == 5'd7))
            mstatus_mpie <= o_csr_in;
         if (i_mie_en & i_en & IMPL[i_cnt])
            mie_q[i_cnt] <= o_csr_in;
         if (i_mcause_en & i_en & (i_cnt < 5'd5))
            mcause_code <= {o_csr_in, mcause_code[4:1]};
         if (i_mcause_en & i_en & i_cnt_done)
            mcause_int <= o_csr_in;

         if (i_cnt_done & !i_init & !o_new_irq & mstatus_mie & irq_any) begin
            o_new_irq <= 1'b1;
            irq_code  <= prio_code;
         end

         if (i_trap & i_cnt_done) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            o_new_irq    <= 1'b0;
            mcause_int   <= o_new_irq;
            mcause_code  <= o_new_irq ? irq_code
                                      : exception_code(i_e_op, i_ebreak, i_mem_op, i_mem_cmd);
         end else if (i_mret & i_cnt_done) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end
      end
   end

   // Pending flag for WFI wakeup, independent of the global enable
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_irq_pending <= 1'b0;
      else
         o_irq_pending <= irq_any;
   end

endmodule

// File: tb/tb_serv_csr_irq.sv
// tb/tb_serv_csr_irq.sv - self-checking bench for serv_csr_irq
module tb_serv_csr_irq;

   localparam int NUM_IRQ     = 4;
   localparam int SYNC_STAGES = 2;
   localparam logic [31:0] IMPL = 32'h0000_0888 | (((32'd1 << NUM_IRQ) - 32'd1) << 16);

   localparam logic [2:0] S_NONE = 3'd0, S_MST = 3'd1, S_MIE = 3'd2, S_MIP = 3'd3, S_MCA = 3'd4;
   localparam logic [1:0] K_CSR = 2'd0, K_TRAP = 2'd1, K_MRET = 2'd2, K_BOTH = 2'd3;
   localparam logic [1:0] SRC_CSR = 2'd0, SRC_WR = 2'd1, SRC_SET = 2'd2, SRC_CLR = 2'd3;

   logic i_clk, i_rst, i_init, i_en, i_cnt_done;
   logic [4:0] i_cnt;
   logic i_trap, i_mret, i_e_op, i_ebreak, i_mem_op, i_mem_cmd;
   logic i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en;
   logic [1:0] i_csr_source;
   logic i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out;
   logic i_mtip, i_msip, i_meip;
   logic [NUM_IRQ-1:0] i_lirq;
   logic o_csr_in, o_q, o_new_irq, o_irq_pending;

   serv_csr_irq #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_en(i_en), .i_cnt_done(i_cnt_done),
      .i_cnt(i_cnt), .i_trap(i_trap), .i_mret(i_mret), .i_e_op(i_e_op), .i_ebreak(i_ebreak),
      .i_mem_op(i_mem_op), .i_mem_cmd(i_mem_cmd), .i_mstatus_en(i_mstatus_en),
      .i_mie_en(i_mie_en), .i_mip_en(i_mip_en), .i_mcause_en(i_mcause_en),
      .i_csr_source(i_csr_source), .i_csr_d_sel(i_csr_d_sel), .i_csr_imm(i_csr_imm),
      .i_rs1(i_rs1), .i_rf_csr_out(i_rf_csr_out), .i_mtip(i_mtip), .i_msip(i_msip),
      .i_meip(i_meip), .i_lirq(i_lirq), .o_csr_in(o_csr_in), .o_q(o_q),
      .o_new_irq(o_new_irq), .o_irq_pending(o_irq_pending)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  sel;
      logic [1:0]  src;
      logic [31:0] d;
      logic [1:0]  kind;
      logic [3:0]  exc;
      logic [31:0] lines;
      logic [31:0] exp_q;
      logic        exp_new;
      logic        exp_pend;
   } vec_t;

   vec_t tbl[$];
   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_mie, m_mcause, m_lines;
   logic        m_ie, m_pie, m_new;
   logic [4:0]  m_code;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_en = 0; i_cnt = 0; i_cnt_done = 0; i_trap = 0; i_mret = 0;
      {i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = 4'h0;
      i_mstatus_en = 0; i_mie_en = 0; i_mip_en = 0; i_mcause_en = 0;
      i_csr_source = 0; i_csr_d_sel = 0; i_csr_imm = 0; i_rs1 = 0; i_rf_csr_out = 0;
   endtask

   task automatic set_lines(input logic [31:0] w);
      i_msip = w[3]; i_mtip = w[7]; i_meip = w[11]; i_lirq = w[16 +: NUM_IRQ];
      repeat (SYNC_STAGES + 3) step();
   endtask

   task automatic do_reset();
      i_rst = 1;
      repeat (2) step();
      i_rst = 0;
   endtask

   task automatic add_vec(input logic [2:0] sel, input logic [1:0] src, input logic [31:0] d,
                          input logic [1:0] kind, input logic [3:0] exc, input logic [31:0] lines,
                          input logic [31:0] exp_q, input logic exp_new, input logic exp_pend);
      vec_t v;
      v.sel = sel; v.src = src; v.d = d; v.kind = kind; v.exc = exc; v.lines = lines;
      v.exp_q = exp_q; v.exp_new = exp_new; v.exp_pend = exp_pend;
      tbl.push_back(v);
   endtask

   // One 32-cycle serial instruction; returns the read bits and the written bits
   task automatic run_instr(input logic [2:0] sel, input logic [1:0] src, input logic [31:0] d,
                            input logic [31:0] rf, input logic [1:0] kind, input logic [3:0] exc,
                            output logic [31:0] q, output logic [31:0] cin);
      logic dsel;
      dsel = 1'($urandom_range(0, 1));
      i_mstatus_en = (sel == S_MST); i_mie_en = (sel == S_MIE);
      i_mip_en = (sel == S_MIP); i_mcause_en = (sel == S_MCA);
      i_csr_source = src; i_csr_d_sel = dsel;
      i_trap = kind[0]; i_mret = kind[1];
      {i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = exc;
      i_en = 1;
      for (int i = 0; i < 32; i++) begin
         i_cnt = 5'(i);
         i_cnt_done = (i == 31);
         i_csr_imm = dsel ? d[i] : ~d[i];
         i_rs1 = dsel ? ~d[i] : d[i];
         i_rf_csr_out = rf[i];
         @(negedge i_clk);
         q[i] = o_q;
         cin[i] = o_csr_in;
         step();
      end
      idle_inputs();
   endtask

   function automatic logic [4:0] model_prio(input logic [31:0] p);
      int order[$];
      order = '{11, 3, 7};
      for (int k = 0; k < NUM_IRQ; k++) order.push_back(16 + k);
      foreach (order[i]) if (p[order[i]]) return 5'(order[i]);
      return 5'd0;
   endfunction

   function automatic logic [31:0] model_exc(input logic [3:0] exc);
      if (exc[3]) return exc[2] ? 32'd3 : 32'd11;
      if (exc[1]) return exc[0] ? 32'd6 : 32'd4;
      return 32'd0;
   endfunction

   initial begin
      logic [31:0] q, cin, rd, nv, d, rf;
      logic [2:0] sel;
      logic [1:0] src, kind;
      logic [3:0] exc;
      int lat;
      bit seen;

      idle_inputs();
      i_init = 0; i_mtip = 0; i_msip = 0; i_meip = 0; i_lirq = '0;
      do_reset();
      @(negedge i_clk);
      chk("reset new_irq", 32'(o_new_irq), 32'd0);
      chk("reset irq_pending", 32'(o_irq_pending), 32'd0);
      step();

      //       sel    src      d             kind    exc    lines         exp_q         new pend
      add_vec(S_MST, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MIE, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MIP, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MIE, SRC_WR,  32'h80,       K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MST, SRC_SET, 32'h8,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MIE, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h80,       32'h80,       1, 1);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h0, 32'h80,       32'h0,        0, 1);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h80,       32'h80000007, 0, 1);
      add_vec(S_MST, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h80,       32'h80,       0, 1);
      add_vec(S_MIE, SRC_WR,  32'h00050008, K_CSR,  4'h0, 32'h0,        32'h80,       0, 0);
      add_vec(S_MST, SRC_SET, 32'h8,        K_CSR,  4'h0, 32'h0,        32'h80,       0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h00050008, 32'h80000007, 1, 1);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h0, 32'h00050008, 32'h0,        0, 1);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h00050008, 32'h80000003, 0, 1);
      add_vec(S_MST, SRC_SET, 32'h8,        K_CSR,  4'h0, 32'h00050000, 32'h80,       1, 1);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h0, 32'h00050000, 32'h0,        0, 1);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h00050000, 32'h80000010, 0, 1);
      add_vec(S_MST, SRC_SET, 32'h8,        K_CSR,  4'h0, 32'h00040000, 32'h80,       1, 1);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h0, 32'h00040000, 32'h0,        0, 1);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h00040000, 32'h80000012, 0, 1);
      add_vec(S_MST, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h00040000, 32'h80,       0, 1);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_MRET, 4'h0, 32'h00040000, 32'h0,        0, 1);
      add_vec(S_MST, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h00040000, 32'h88,       1, 1);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h0, 32'h00040000, 32'h0,        0, 1);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h8, 32'h0,        32'h0,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0000000B, 0, 0);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_BOTH, 4'h8, 32'h0,        32'h0,        0, 0);
      add_vec(S_MST, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0000000B, 0, 0);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'hC, 32'h0,        32'h0,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h3,        0, 0);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h3, 32'h0,        32'h0,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h6,        0, 0);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h2, 32'h0,        32'h0,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h4,        0, 0);
      add_vec(S_MIE, SRC_WR,  32'h0,        K_CSR,  4'h0, 32'h0,        32'h00050008, 0, 0);
      add_vec(S_MIE, SRC_SET, 32'h00010880, K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MIE, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h00010880, 0, 0);
      add_vec(S_MIE, SRC_CLR, 32'h00010880, K_CSR,  4'h0, 32'h0,        32'h00010880, 0, 0);
      add_vec(S_MIE, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MIP, SRC_WR,  32'hFFFFFFFF, K_CSR,  4'h0, 32'h808,      32'h808,      0, 0);
      add_vec(S_MIP, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h808,      32'h808,      0, 0);
      add_vec(S_MCA, SRC_WR,  32'h8000001F, K_CSR,  4'h0, 32'h0,        32'h4,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h8000001F, 0, 0);
      add_vec(S_NONE,SRC_CSR, 32'h0,        K_TRAP, 4'h0, 32'h0,        32'h0,        0, 0);
      add_vec(S_MCA, SRC_CSR, 32'h0,        K_CSR,  4'h0, 32'h0,        32'h0,        0, 0);

      foreach (tbl[i]) begin
         set_lines(tbl[i].lines);
         run_instr(tbl[i].sel, tbl[i].src, tbl[i].d, 32'h0, tbl[i].kind, tbl[i].exc, q, cin);
         @(negedge i_clk);
         chk($sformatf("vec%0d read", i), q, tbl[i].exp_q);
         chk($sformatf("vec%0d new_irq", i), 32'(o_new_irq), 32'(tbl[i].exp_new));
         chk($sformatf("vec%0d irq_pending", i), 32'(o_irq_pending), 32'(tbl[i].exp_pend));
         step();
      end

      // line-to-pending latency with mie.MTIE set
      run_instr(S_MIE, SRC_WR, 32'h80, 32'h0, K_CSR, 4'h0, q, cin);
      lat = 0; seen = 0;
      i_mtip = 1;
      while (!seen && lat < 20) begin
         step();
         lat++;
         @(negedge i_clk);
         seen = o_irq_pending;
      end
      step();
      chk("pending latency", 32'(lat), 32'(SYNC_STAGES + 2));
      run_instr(S_MST, SRC_SET, 32'h8, 32'h0, K_CSR, 4'h0, q, cin);
      @(negedge i_clk);
      chk("accept before reset", 32'(o_new_irq), 32'd1);
      step();

      // reset in the middle of an instruction discards the accepted interrupt
      i_en = 1; i_mie_en = 1; i_csr_source = SRC_WR; i_rs1 = 1;
      for (int i = 0; i < 10; i++) begin
         i_cnt = 5'(i);
         step();
      end
      i_rst = 1;
      step();
      i_rst = 0;
      idle_inputs();
      @(negedge i_clk);
      chk("midreset new_irq", 32'(o_new_irq), 32'd0);
      chk("midreset pending", 32'(o_irq_pending), 32'd0);
      step();
      run_instr(S_MIE, SRC_CSR, 32'h0, 32'h0, K_CSR, 4'h0, q, cin);
      chk("midreset mie", q, 32'h0);
      run_instr(S_MST, SRC_CSR, 32'h0, 32'h0, K_CSR, 4'h0, q, cin);
      chk("midreset mstatus", q, 32'h0);

      // randomized instructions against the reference model
      do_reset();
      m_mie = 0; m_mcause = 0; m_ie = 0; m_pie = 0; m_new = 0; m_code = 0; m_lines = 0;
      set_lines(m_lines);
      for (int n = 0; n < 250; n++) begin
         int r;
         if ($urandom_range(0, 3) == 0) begin
            m_lines = $urandom & IMPL;
            set_lines(m_lines);
         end
         r = $urandom_range(0, 9);
         exc = 4'($urandom);
         d = $urandom;
         if ($urandom_range(0, 1) == 1) d = d & (IMPL | 32'h8000_009F);
         src = 2'($urandom);
         if (r < 6) begin
            sel = 3'($urandom_range(1, 4));
            kind = K_CSR;
         end else begin
            sel = S_NONE;
            kind = (r < 8) ? K_TRAP : K_MRET;
         end
         rf = (sel == S_NONE) ? 32'($urandom) : 32'h0;

         case (sel)
            S_MST:   rd = (32'(m_pie) << 7) | (32'(m_ie) << 3);
            S_MIE:   rd = m_mie;
            S_MIP:   rd = m_lines;
            S_MCA:   rd = m_mcause;
            default: rd = rf;
         endcase
         case (src)
            SRC_WR:  nv = d;
            SRC_SET: nv = rd | d;
            SRC_CLR: nv = rd & ~d;
            default: nv = rd;
         endcase
         if (sel == S_MST) begin m_ie = nv[3]; m_pie = nv[7]; end
         if (sel == S_MIE) m_mie = nv & IMPL;
         if (sel == S_MCA) m_mcause = nv & 32'h8000_001F;
         if (kind == K_TRAP) begin
            m_pie = m_ie;
            m_ie = 0;
            m_mcause = m_new ? (32'h8000_0000 | 32'(m_code)) : model_exc(exc);
            m_new = 0;
         end else begin
            if (!m_new && m_ie && ((m_lines & m_mie) != 0)) begin
               m_new = 1;
               m_code = model_prio(m_lines & m_mie);
            end
            if (kind == K_MRET) begin m_ie = m_pie; m_pie = 1; end
         end

         run_instr(sel, src, d, rf, kind, exc, q, cin);
         @(negedge i_clk);
         chk($sformatf("rnd%0d read sel%0d", n, sel), q, rd);
         chk($sformatf("rnd%0d csr_in src%0d", n, src), cin, nv);
         chk($sformatf("rnd%0d new_irq", n), 32'(o_new_irq), 32'(m_new));
         chk($sformatf("rnd%0d irq_pending", n), 32'(o_irq_pending), 32'((m_lines & m_mie) != 0));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serv_csr_irq.md
# serv_csr_irq

Parametrised bit-serial machine-mode CSR and interrupt unit, next generation of the SERV CSR block. It adds software (MSIP), external (MEIP) and NUM_IRQ platform-local interrupt lines on top of the timer interrupt, with fixed-priority arbitration into mcause. mstatus.MPIE and mip become readable. It sits beside the serial ALU/register file, consumes one CSR bit per cycle under the SERV bit counter, and signals the decoder/state machine to take a trap.

## Interface
- NUM_IRQ, 4, number of local interrupt lines (1..16), mapped to mie/mip bits 16..16+NUM_IRQ-1
- SYNC_STAGES, 2, synchroniser flops on every interrupt input (0, 1 or 2)
- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_init, i_en, i_cnt_done  in  1  SERV state: init phase, serial-data valid, last bit (cnt==31)
- i_cnt  in  5  current serial bit index
- i_trap, i_mret  in  1  trap entry / mret in progress
- i_e_op, i_ebreak, i_mem_op, i_mem_cmd  in  1  exception qualifiers (ecall/ebreak, misaligned mem, store=1)
- i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en  in  1  decoded CSR select
- i_csr_source  in  2  00 CSR, 01 write, 10 set, 11 clear
- i_csr_d_sel, i_csr_imm, i_rs1  in  1  operand select, zimm bit, rs1 bit
- i_rf_csr_out  in  1  serial bit of register-file-backed CSRs (mscratch, mepc, mtvec, mtval)
- i_mtip, i_msip, i_meip  in  1  level-sensitive interrupt lines
- i_lirq  in  NUM_IRQ  level-sensitive local interrupt lines
- o_csr_in  out  1  new serial CSR bit after the write/set/clear operation
- o_q  out  1  serial CSR read bit
- o_new_irq  out  1  interrupt accepted, take trap at next instruction
- o_irq_pending  out  1  any enabled line pending, regardless of mstatus.MIE (for WFI wakeup)

## Operation
- d = i_csr_d_sel ? i_csr_imm : i_rs1. o_csr_in is csr_out, d, csr_out|d or csr_out&~d, selected by source.
- csr_out = i_rf_csr_out OR the selected internal bit at index i_cnt:
  - mstatus bit3 = MIE, bit7 = MPIE.
  - mie/mip bits 3, 7, 11, 16+k.
  - mcause bits 0..4 = code, bit31 = interrupt flag.
  - Unimplemented bits read 0.
- Writes occur when i_en and the select are active at the matching i_cnt. mip is read-only; writes are ignored.
- mcause code is a 5-bit rotate register. When i_mcause_en & i_en & i_cnt<5, code <= {o_csr_in, code[4:1]} and the read bit is code[0]. Bit31 is written at i_cnt_done.
- Pending vector p = mip & mie, where mip holds the synchronised lines.
- Priority: MEI(11) > MSI(3) > MTI(7) > local lines, lowest index first. Local line k gives code 16+k.
- Acceptance: at i_cnt_done & !i_init & !o_new_irq & MIE & |p, set o_new_irq and latch irq_code.
- On i_trap & i_cnt_done:
  - MPIE <= MIE, MIE <= 0, o_new_irq <= 0.
  - mcause31 <= o_new_irq.
  - code <= o_new_irq ? irq_code : exception code. Exception codes: ebreak 3, ecall 11, load misaligned 4, store misaligned 6, jump misaligned 0.
- On i_mret at i_cnt_done: MIE <= MPIE, MPIE <= 1.
- Arbitration is level-sensitive. A line that deasserts after acceptance still traps with the latched code.

## Timing
- Reset values are all 0: MIE, MPIE, mie, mcause, irq_code, synchronisers, o_new_irq, o_irq_pending.
- Line to mip latency is SYNC_STAGES+1 cycles. o_irq_pending is registered, one cycle after mip.
- o_new_irq rises the cycle after the accepting i_cnt_done. It holds until trap completion or reset.
- i_trap and i_mret are exclusive; if both are asserted, trap wins.
- A CSR write to MIE and trap completion in the same cycle resolve to trap: MIE = 0.
- Reset mid-instruction discards the serial state and any pending acceptance.

## Structure
- Shared package serv_csr_pkg holds:
  - CSR_SOURCE_* constants.
  - mie/mip bit positions (3, 7, 11, 16).
  - Cause codes (0, 3, 4, 6, 7, 11).
- Sub-module serv_irq_prio takes the synchronisers and the priority encoder (p vector → any, 5-bit code).

## Test plan
- Reset, then read mstatus/mie/mip/mcause → all 32 bits read 0. o_new_irq and o_irq_pending are 0.
- Set mie.MTIE and mstatus.MIE, assert i_mtip → o_new_irq after SYNC_STAGES+1 cycles plus the next i_cnt_done. Trap completion gives mcause 0x80000007, MIE=0, MPIE=1.
- NUM_IRQ=4: assert i_lirq[2], i_lirq[0] and i_msip together, all enabled → mcause 0x80000003. After clearing msip: 0x80000010. Then 0x80000012.
- Local line asserted but mstatus.MIE=0 → o_irq_pending=1, o_new_irq stays 0. Then mret with MPIE=1 → interrupt taken after the next instruction.
- Ecall trap → mcause 0x0000000B. Ebreak → 0x3. Misaligned store → 0x6. Misaligned load → 0x4.
- csrrs/csrrc on mie with rs1=0x00010880 → bits 7, 11, 16 set, then cleared. The write to mip leaves mip unchanged.
